// File: rtl/noaa_sample_feeder.sv
// noaa_sample_feeder
// Buffers raw sensor readings and feeds one full window of them to the NOAA
// averaging module. It then steps MODE to read back the window mean and the
// iterated std-dev, and holds both results on a valid/ready port until they
// are taken.
module noaa_sample_feeder #(
    parameter int WIDTH       = 12,
    parameter int WINDOW      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SETTLE      = 1,
    parameter int SIGMA_ITERS = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_VALID,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             WR_READY,
    output logic             NOAA_RESET,
    input  logic             SAMPLE,
    output logic [WIDTH-1:0] TN,
    output logic             MODE,
    input  logic [WIDTH-1:0] AVG_SD,
    input  logic             DONE,
    output logic             RES_VALID,
    output logic [WIDTH-1:0] RES_MEAN,
    output logic [WIDTH-1:0] RES_SD,
    input  logic             RES_READY
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 8;  // phase counter width, covers WINDOW, SETTLE and SIGMA_ITERS

    typedef enum logic [2:0] {
        S_CLEAR,
        S_WAIT,
        S_STREAM,
        S_HOLD,
        S_MEAN,
        S_SIGMA,
        S_REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, cap_mean, cap_sd, res_ack;
    logic             unused_done;

    // Sequencing uses cycle counts, so the NOAA done flag is not needed.
    assign unused_done = DONE;

    // Readiness comes from the registered count. When the FIFO is full, a pop in
    // the same cycle does not free the slot until the next cycle.
    assign WR_READY   = !RESET && (count < (AW+1)'(FIFO_DEPTH));
    assign push       = WR_VALID && WR_READY;
    assign NOAA_RESET = RESET || (state_q == S_CLEAR);
    assign MODE       = !RESET && (state_q == S_SIGMA);

    // Store accepted readings in the buffer.
    // NOTE: the storage array has no reset; it is only read at entries the pointers
    // have marked valid, so clearing it would cost a reset path on every cell for nothing.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    // Track the buffer pointers and occupancy. A reset discards all buffered readings.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the values from before the edge, whatever order the blocks evaluate in.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Register the state and the phase counter for the current state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_CLEAR;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next-state decode: window sequencing plus the pop and capture strobes.
    // NOTE: every signal this block writes gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        cap_mean = 1'b0;
        cap_sd   = 1'b0;
        res_ack  = 1'b0;
        case (state_q)
            S_CLEAR: state_d = S_WAIT;
            S_WAIT: begin
                // NOAA samples every cycle once started, so only start a full window.
                if (SAMPLE && (count >= (AW+1)'(WINDOW))) state_d = S_STREAM;
            end
            S_STREAM: begin
                pop = 1'b1;
                if (phase_q == PW'(WINDOW - 1)) state_d = S_HOLD;
            end
            S_HOLD: state_d = S_MEAN;
            S_MEAN: begin
                if (phase_q == PW'(SETTLE - 1)) begin
                    cap_mean = 1'b1;
                    state_d  = S_SIGMA;
                end
            end
            S_SIGMA: begin
                if (phase_q == PW'(SIGMA_ITERS - 1)) begin
                    cap_sd  = 1'b1;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (RES_READY) begin
                    res_ack = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            default: state_d = S_CLEAR;
        endcase
        phase_d = (state_d != state_q) ? '0 : phase_q + 1'b1;
    end

    // Present the popped reading to NOAA. TN keeps the last value between windows.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            TN <= '0;
        end else if (pop) begin
            TN <= mem[rd_ptr];
        end
    end

    // Capture the mean and std-dev, and handle the result handshake.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            RES_VALID <= 1'b0;
            RES_MEAN  <= '0;
            RES_SD    <= '0;
        end else begin
            if (cap_mean) RES_MEAN <= AVG_SD;
            if (cap_sd) begin
                RES_SD    <= AVG_SD;
                RES_VALID <= 1'b1;
            end else if (res_ack) begin
                RES_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noaa_sample_feeder.sv
// tb_noaa_sample_feeder
// Directed bench for noaa_sample_feeder. A small NOAA model drives AVG_SD. Expected
// result pairs go into a scoreboard queue, and a monitor checks each pair when the
// result handshake fires. The stimulus process checks TN, MODE and the timing itself.
module tb_noaa_sample_feeder;

    localparam int WIDTH       = 12;
    localparam int WINDOW      = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int SETTLE      = 1;
    localparam int SIGMA_ITERS = 4;

    typedef struct {
        logic [WIDTH-1:0] mean;
        logic [WIDTH-1:0] sd;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_ready;
    logic             noaa_reset;
    logic             sample = 1'b0;
    logic [WIDTH-1:0] tn;
    logic             mode;
    logic [WIDTH-1:0] avg_sd;
    logic             done = 1'b0;
    logic             res_valid;
    logic [WIDTH-1:0] res_mean;
    logic [WIDTH-1:0] res_sd;
    logic             res_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    res_t             exp_q[$];
    logic [WIDTH-1:0] model_fifo[$];
    logic [WIDTH-1:0] mean_val = '0;
    logic [WIDTH-1:0] sd_val = '0;
    logic [WIDTH-1:0] k = '0;

    noaa_sample_feeder #(
        .WIDTH(WIDTH), .WINDOW(WINDOW), .FIFO_DEPTH(FIFO_DEPTH),
        .SETTLE(SETTLE), .SIGMA_ITERS(SIGMA_ITERS)
    ) dut (
        .CLK(clk), .RESET(rst), .WR_VALID(wr_valid), .WR_DATA(wr_data),
        .WR_READY(wr_ready), .NOAA_RESET(noaa_reset), .SAMPLE(sample), .TN(tn),
        .MODE(mode), .AVG_SD(avg_sd), .DONE(done), .RES_VALID(res_valid),
        .RES_MEAN(res_mean), .RES_SD(res_sd), .RES_READY(res_ready)
    );

    always #5 clk = ~clk;

    // NOAA model: the mean is constant. The std-dev walks up one step per MODE=1
    // cycle and equals sd_val only on the last iteration.
    always @(posedge clk) k <= mode ? k + 1'b1 : '0;
    assign avg_sd = mode ? (sd_val - WIDTH'(SIGMA_ITERS - 1) + k) : mean_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one reading. The model decides acceptance from its own occupancy.
    task automatic write(input logic [WIDTH-1:0] d);
        logic exp_ready;
        exp_ready = (model_fifo.size() < FIFO_DEPTH);
        check("wr_ready", 32'(wr_ready), 32'(exp_ready));
        wr_valid = 1'b1;
        wr_data  = d;
        if (exp_ready) model_fifo.push_back(d);
        tick();
        wr_valid = 1'b0;
    endtask

    // Run one window from WAIT with at least WINDOW readings buffered. Holds the
    // result for bp cycles before accepting it.
    task automatic run_window(input logic [WIDTH-1:0] mean, input logic [WIDTH-1:0] sd,
                              input int bp);
        res_t e;
        logic [WIDTH-1:0] want;
        mean_val = mean;
        sd_val   = sd;
        e.mean   = mean;
        e.sd     = sd;
        exp_q.push_back(e);
        sample = 1'b1;
        tick();                       // WAIT -> STREAM edge
        sample = 1'b0;
        for (int i = 0; i < WINDOW; i++) begin
            tick();
            @(negedge clk);
            want = model_fifo.pop_front();
            check("tn_stream", 32'(tn), 32'(want));
        end
        check("mode_hold", 32'(mode), 32'd0);
        for (int i = 0; i < SETTLE; i++) begin
            tick();
            @(negedge clk);
            check("mode_mean", 32'(mode), 32'd0);
            check("valid_early", 32'(res_valid), 32'd0);
        end
        for (int i = 0; i < SIGMA_ITERS; i++) begin
            tick();
            @(negedge clk);
            check("mode_sigma", 32'(mode), 32'd1);
            check("valid_early", 32'(res_valid), 32'd0);
        end
        tick();
        @(negedge clk);
        check("valid_latency", 32'(res_valid), 32'd1);
        check("mode_report", 32'(mode), 32'd0);
        for (int i = 0; i < bp; i++) begin
            tick();
            @(negedge clk);
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_mean", 32'(res_mean), 32'(mean));
            check("bp_sd", 32'(res_sd), 32'(sd));
            check("bp_no_window", 32'(noaa_reset), 32'd0);
        end
        tick();
        res_ready = 1'b1;
        tick();                       // accept edge
        res_ready = 1'b0;
        @(negedge clk);
        check("valid_cleared", 32'(res_valid), 32'd0);
        check("noaa_reset_pulse", 32'(noaa_reset), 32'd1);
        tick();
        @(negedge clk);
        check("noaa_reset_single", 32'(noaa_reset), 32'd0);
    endtask

    // Monitor: whenever a result is taken, compare it against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got mean 0x%0h sd 0x%0h expected none",
                         res_mean, res_sd);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("sb_mean", 32'(res_mean), 32'(e.mean));
                check("sb_sd", 32'(res_sd), 32'(e.sd));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset behaviour while RESET is held, then a single CLEAR cycle after release.
        #1;
        tick();
        @(negedge clk);
        check("rst_noaa_reset", 32'(noaa_reset), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_tn", 32'(tn), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_res_mean", 32'(res_mean), 32'd0);
        check("rst_res_sd", 32'(res_sd), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("clear_noaa_reset", 32'(noaa_reset), 32'd1);
        tick();
        @(negedge clk);
        check("wait_noaa_reset", 32'(noaa_reset), 32'd0);
        tick();

        // Basic window with 10 cycles of result backpressure.
        for (int i = 1; i <= 8; i++) write(WIDTH'(12'h400 + i));
        run_window(12'h420, 12'h060, 10);

        // Fill to full and overflow by one. The write pointer starts mid-buffer,
        // so the stored data wraps around the end of the array.
        for (int i = 0; i < 17; i++) write(WIDTH'(12'h500 + i));
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        run_window(12'h111, 12'h022, 0);
        run_window(12'h133, 12'h044, 0);

        // A partial window must not start; the 8th reading lets it start.
        sample = 1'b1;
        for (int i = 0; i < 7; i++) write(WIDTH'(12'h600 + i));
        repeat (3) tick();
        @(negedge clk);
        check("partial_tn_hold", 32'(tn), 32'h50f);
        check("partial_mode", 32'(mode), 32'd0);
        check("partial_no_valid", 32'(res_valid), 32'd0);
        tick();
        write(12'h607);
        run_window(12'h603, 12'h002, 2);

        // Abort mid-stream after 3 pops: no result, buffer emptied, fresh CLEAR.
        for (int i = 0; i < 8; i++) write(WIDTH'(12'h700 + i));
        sample = 1'b1;
        tick();                       // enter STREAM
        repeat (3) tick();            // three pops
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_fifo.delete();
        @(negedge clk);
        check("abort_noaa_reset", 32'(noaa_reset), 32'd1);
        check("abort_tn", 32'(tn), 32'd0);
        check("abort_mode", 32'(mode), 32'd0);
        check("abort_wr_ready", 32'(wr_ready), 32'd1);
        res_ready = 1'b1;
        repeat (25) tick();
        @(negedge clk);
        check("abort_no_result", 32'(res_valid), 32'd0);
        check("abort_no_stream", 32'(tn), 32'd0);
        res_ready = 1'b0;
        sample = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) write(WIDTH'(12'h800 + 3 * i));
        run_window(12'h80a, 12'h007, 0);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
